uc_seq: RTL and testbench

Multi-cycle sequencing control unit for the `microc` datapath. It replaces the single-cycle opcode decode with a registered decode/execute sequence. It also adds run/halt/single-step control, an executed-instruction counter and sticky illegal-opcode detection. It sits beside `microc`: it drives the datapath control inputs plus a PC-register write enable `pc_en`, which the top level wires to the enable of `microc`'s PC register.

---
 rtl/uc_seq.sv | 134 +++++++++++++
 tb/tb_uc_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uc_seq.sv
// Multi-cycle decode/execute sequencer for the microc datapath.
// It provides run/halt/single-step control, an executed-instruction counter and a sticky illegal-opcode flag.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_HALT   | idle; waits for run or a step rising edge (or reset if illegal)
// S_DECODE | latch Opcode into IR and z into ZR, check the opcode is defined
// S_EXEC   | drive decoded controls and pc_en, count the instruction
module uc_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             run,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_HALT   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       ir_q, ir_d;
  logic             zr_q, zr_d;
  logic             step_q;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_rise;

  function automatic logic is_legal(input logic [5:0] op);
    is_legal = op[5]
            || (op == 6'b000000)
            || (op[5:2] == 4'b0001)
            || (op == 6'b010000)
            || (op == 6'b010001)
            || (op == 6'b010010);
  endfunction

  assign step_rise = step & ~step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HALT;
      ir_q    <= 6'd0;
      zr_q    <= 1'b0;
      step_q  <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      zr_q    <= zr_d;
      step_q  <= step;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    zr_d    = zr_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_HALT: begin
        // A faulted sequencer only leaves HALT through reset.
        if (!ill_q && (run || step_rise)) state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d = Opcode;
        zr_d = z;
        if (is_legal(Opcode)) begin
          state_d = S_EXEC;
        end else begin
          ill_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = run ? S_DECODE : S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Outputs come only from registered state, so Opcode/z/run/step never reach them combinationally.
  always_comb begin
    s_inc = 1'b0;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    Op    = 3'b000;
    pc_en = 1'b0;
    if (state_q == S_EXEC) begin
      pc_en = 1'b1;
      if (ir_q[5]) begin
        s_inc = 1'b1;
        we3   = 1'b1;
        wez   = 1'b1;
        Op    = ir_q[4:2];
      end else if (ir_q == 6'b000000) begin
        s_inc = 1'b1;
      end else if (ir_q[5:2] == 4'b0001) begin
        s_inc = 1'b1;
        s_inm = 1'b1;
        we3   = 1'b1;
      end else if (ir_q == 6'b010001) begin
        s_inc = ~zr_q;
      end else if (ir_q == 6'b010010) begin
        s_inc = zr_q;
      end
    end
  end

  assign halted      = (state_q == S_HALT);
  assign illegal     = ill_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_uc_seq.sv
// Directed bench for uc_seq: a vector table of single-stepped opcodes plus
// hand-written sequences for reset, free-run, step, illegal, abort and wrap.
module tb_uc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Opcode;
  logic        z, run, step;
  logic        s_inc, s_inm, we3, wez, pc_en, halted, illegal;
  logic [2:0]  Op;
  logic [15:0] instr_count;
  logic        w_s_inc, w_s_inm, w_we3, w_wez, w_pc_en, w_halted, w_illegal;
  logic [2:0]  w_Op;
  logic [1:0]  w_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uc_seq dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run(run), .step(step),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .pc_en(pc_en), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  uc_seq #(.CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run(run), .step(step),
    .s_inc(w_s_inc), .s_inm(w_s_inm), .we3(w_we3), .wez(w_wez), .Op(w_Op),
    .pc_en(w_pc_en), .halted(w_halted), .illegal(w_illegal), .instr_count(w_count)
  );

  typedef struct {
    string      name;
    logic [5:0] opc;
    logic       zin;
    logic [6:0] ctl;   // {s_inc, s_inm, we3, wez, Op}
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {s_inc, s_inm, we3, wez, Op};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  int pulses;

  initial begin
    vecs[0] = '{"li",       6'b000100, 1'b0, 7'b1110_000};
    vecs[1] = '{"li_hi",    6'b000111, 1'b1, 7'b1110_000};
    vecs[2] = '{"alu_010",  6'b101000, 1'b0, 7'b1011_010};
    vecs[3] = '{"alu_111",  6'b111111, 1'b1, 7'b1011_111};
    vecs[4] = '{"nop",      6'b000000, 1'b1, 7'b1000_000};
    vecs[5] = '{"j",        6'b010000, 1'b0, 7'b0000_000};
    vecs[6] = '{"jz_z1",    6'b010001, 1'b1, 7'b0000_000};
    vecs[7] = '{"jz_z0",    6'b010001, 1'b0, 7'b1000_000};
    vecs[8] = '{"jnz_z1",   6'b010010, 1'b1, 7'b1000_000};
    vecs[9] = '{"jnz_z0",   6'b010010, 1'b0, 7'b0000_000};

    // reset hold with run high, then first pc_en two cycles after release
    reset = 1'b1; run = 1'b1; step = 1'b0; Opcode = 6'd0; z = 1'b0;
    tick(); tick(); tick();
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_ctl", 32'({ctl(), pc_en}), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    tick();
    chk("start_decode_pc_en", 32'(pc_en), 32'd0);
    chk("start_decode_halted", 32'(halted), 32'd0);
    tick();
    chk("start_exec_pc_en", 32'(pc_en), 32'd1);
    run = 1'b0;
    tick();
    chk("start_halt_count", 32'(instr_count), 32'd1);
    chk("start_halted", 32'(halted), 32'd1);

    // free-running li, ALU, nop
    do_reset();
    run = 1'b1; Opcode = 6'b000100;
    tick(); tick();
    chk("free_li", 32'({ctl(), pc_en}), 32'({7'b1110_000, 1'b1}));
    Opcode = 6'b101000;
    tick(); tick();
    chk("free_alu", 32'({ctl(), pc_en}), 32'({7'b1011_010, 1'b1}));
    Opcode = 6'b000000;
    tick(); tick();
    chk("free_nop", 32'({ctl(), pc_en}), 32'({7'b1000_000, 1'b1}));
    run = 1'b0;
    tick();
    chk("free_count", 32'(instr_count), 32'd3);
    chk("free_halted", 32'(halted), 32'd1);

    // vector table, each one single-stepped; z toggled in EXEC must not matter
    do_reset();
    for (int i = 0; i < 10; i++) begin
      Opcode = vecs[i].opc; z = vecs[i].zin;
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      chk({vecs[i].name, "_ctl"}, 32'(ctl()), 32'(vecs[i].ctl));
      chk({vecs[i].name, "_pc_en"}, 32'(pc_en), 32'd1);
      z = ~z;
      #1;
      chk({vecs[i].name, "_ztoggle"}, 32'(ctl()), 32'(vecs[i].ctl));
      tick();
      chk({vecs[i].name, "_halted"}, 32'(halted), 32'd1);
    end
    chk("table_count", 32'(instr_count), 32'd10);

    // step held high for 5 cycles counts once
    do_reset();
    Opcode = 6'd0; z = 1'b0;
    pulses = 0;
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pc_en) pulses++;
    end
    step = 1'b0;
    tick();
    chk("step_hold_pulses", 32'(pulses), 32'd1);
    chk("step_hold_count", 32'(instr_count), 32'd1);
    chk("step_hold_halted", 32'(halted), 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(); tick();
    chk("step_second_count", 32'(instr_count), 32'd2);

    // run dropped during DECODE still completes that instruction
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    chk("drop_run_exec", 32'(pc_en), 32'd1);
    tick();
    chk("drop_run_halted", 32'(halted), 32'd1);
    chk("drop_run_count", 32'(instr_count), 32'd3);

    // illegal opcode: sticky halt despite run and steps
    do_reset();
    pulses = 0;
    run = 1'b1; Opcode = 6'b010011;
    tick();
    chk("ill_decode_flag", 32'(illegal), 32'd0);
    tick();
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step = i[0];
      tick();
      if (pc_en || !halted) pulses++;
    end
    step = 1'b0;
    chk("ill_stuck", 32'(pulses), 32'd0);
    chk("ill_count", 32'(instr_count), 32'd0);
    chk("ill_sticky", 32'(illegal), 32'd1);
    do_reset();
    #1;
    chk("ill_cleared", 32'(illegal), 32'd0);
    chk("ill_cleared_halted", 32'(halted), 32'd1);

    // reset during EXEC aborts the instruction
    run = 1'b1; Opcode = 6'b000000;
    tick(); tick();
    chk("abort_exec_pc_en", 32'(pc_en), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    chk("abort_pc_en", 32'(pc_en), 32'd0);
    chk("abort_count", 32'(instr_count), 32'd0);
    chk("abort_halted", 32'(halted), 32'd1);

    // 2-bit counter wraps: 5 instructions leave 1
    do_reset();
    run = 1'b1; Opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      tick(); tick();
      if (i == 4) run = 1'b0;
    end
    tick();
    chk("wrap_count_w2", 32'(w_count), 32'd1);
    chk("wrap_count_w16", 32'(instr_count), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
